// File: rtl/reset_sequencer_pf.sv
// Reset sequencer: releases NUM_STAGES reset domains one at a time, in
// ascending order. Each stage waits STAGE_DELAY cycles before its release.
// It then waits up to TIMEOUT cycles for that domain's ack. A timeout, or an
// ack lost after the whole sequence completes, parks the block in ERROR with
// every domain held in reset. SOFT_RST_REQ re-runs the sequence from stage 0.
module reset_sequencer_pf #(
  parameter int NUM_STAGES  = 4,
  parameter int STAGE_DELAY = 16,
  parameter int TIMEOUT     = 256
) (
  input  logic                  CLK,
  input  logic                  INTERNAL_RST,
  input  logic                  SOFT_RST_REQ,
  input  logic [NUM_STAGES-1:0] STAGE_ACK,
  output logic [NUM_STAGES-1:0] STAGE_RESET_N,
  output logic                  SEQ_DONE,
  output logic                  SEQ_ERROR,
  output logic [2:0]            ERR_STAGE
);

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_WAIT_ACK,
    ST_DONE,
    ST_ERROR,
    ST_ASSERT
  } state_t;

  localparam logic [15:0]           HOLD_LAST = 16'(STAGE_DELAY - 1);
  localparam logic [15:0]           TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [2:0]            IDX_LAST  = 3'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] STAGE_ONE = NUM_STAGES'(1);

  // ack synchroniser
  logic [NUM_STAGES-1:0] r_ack_meta;
  logic [NUM_STAGES-1:0] r_ack_s;

  // sequencer state
  state_t      r_state;
  state_t      w_nxt_state;
  logic [2:0]  r_idx;
  logic [2:0]  w_nxt_idx;
  logic [15:0] r_cnt;
  logic [15:0] w_nxt_cnt;

  // decoded ack conditions
  logic        w_ack_cur;
  logic        w_all_acked;
  logic [2:0]  w_drop_idx;

  // registered outputs and their next values
  logic [NUM_STAGES-1:0] r_rst_n;
  logic [NUM_STAGES-1:0] w_nxt_rst_n;
  logic                  r_done;
  logic                  w_nxt_done;
  logic                  r_err;
  logic                  w_nxt_err;
  logic [2:0]            r_err_stage;
  logic [2:0]            w_nxt_err_stage;

  // Two-flop synchroniser per ack; acks can come from any clock domain.
  always_ff @(posedge CLK or negedge INTERNAL_RST) begin
    if (!INTERNAL_RST) begin
      r_ack_meta <= '0;
      r_ack_s    <= '0;
    end else begin
      r_ack_meta <= STAGE_ACK;
      r_ack_s    <= r_ack_meta;
    end
  end

  // Decode the ack of the stage being waited on, plus the lowest dropped ack.
  // The mask form keeps the 3-bit index legal for any NUM_STAGES.
  always_comb begin
    w_ack_cur   = |(r_ack_s & (STAGE_ONE << r_idx));
    w_all_acked = &r_ack_s;
    w_drop_idx  = 3'd0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!(|(r_ack_s & (STAGE_ONE << i)))) begin
        w_drop_idx = 3'(i);
      end
    end
  end

  // State register, together with the stage index and the cycle counter.
  always_ff @(posedge CLK or negedge INTERNAL_RST) begin
    if (!INTERNAL_RST) begin
      r_state <= ST_HOLD;
      r_idx   <= 3'd0;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_nxt_state;
      r_idx   <= w_nxt_idx;
      r_cnt   <= w_nxt_cnt;
    end
  end

  // Next-state logic. A soft request beats every other event, except in
  // ASSERT, which always completes its single cycle.
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_idx   = r_idx;
    w_nxt_cnt   = r_cnt;
    if (SOFT_RST_REQ && (r_state != ST_ASSERT)) begin
      w_nxt_state = ST_ASSERT;
      w_nxt_idx   = 3'd0;
      w_nxt_cnt   = 16'd0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_nxt_state = ST_RELEASE;
            w_nxt_cnt   = 16'd0;
          end else begin
            w_nxt_cnt = r_cnt + 16'd1;
          end
        end
        ST_RELEASE: begin
          w_nxt_state = ST_WAIT_ACK;
          w_nxt_cnt   = 16'd0;
        end
        ST_WAIT_ACK: begin
          // The ack is checked first, so it wins when it lands on the
          // final timeout cycle.
          if (w_ack_cur) begin
            w_nxt_cnt = 16'd0;
            if (r_idx == IDX_LAST) begin
              w_nxt_state = ST_DONE;
            end else begin
              w_nxt_state = ST_HOLD;
              w_nxt_idx   = r_idx + 3'd1;
            end
          end else if (r_cnt == TO_LAST) begin
            w_nxt_state = ST_ERROR;
          end else begin
            w_nxt_cnt = r_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          if (!w_all_acked) begin
            w_nxt_state = ST_ERROR;
          end
        end
        ST_ERROR: begin
          w_nxt_state = ST_ERROR;
        end
        ST_ASSERT: begin
          w_nxt_state = ST_HOLD;
          w_nxt_idx   = 3'd0;
          w_nxt_cnt   = 16'd0;
        end
        default: begin
          w_nxt_state = ST_HOLD;
          w_nxt_idx   = 3'd0;
          w_nxt_cnt   = 16'd0;
        end
      endcase
    end
  end

  // Output logic. Next output values come from the transition being taken,
  // so every output changes on the same edge as the state change.
  always_comb begin
    w_nxt_rst_n     = r_rst_n;
    w_nxt_done      = r_done;
    w_nxt_err       = r_err;
    w_nxt_err_stage = r_err_stage;
    if (w_nxt_state == ST_ASSERT) begin
      w_nxt_rst_n     = '0;
      w_nxt_done      = 1'b0;
      w_nxt_err       = 1'b0;
      w_nxt_err_stage = 3'd0;
    end else if ((w_nxt_state == ST_ERROR) && (r_state != ST_ERROR)) begin
      w_nxt_rst_n     = '0;
      w_nxt_done      = 1'b0;
      w_nxt_err       = 1'b1;
      w_nxt_err_stage = (r_state == ST_DONE) ? w_drop_idx : r_idx;
    end else if (r_state == ST_RELEASE) begin
      w_nxt_rst_n = r_rst_n | (STAGE_ONE << r_idx);
    end else if (w_nxt_state == ST_DONE) begin
      w_nxt_done = 1'b1;
    end
  end

  // Output registers; nothing reaches a port combinationally.
  always_ff @(posedge CLK or negedge INTERNAL_RST) begin
    if (!INTERNAL_RST) begin
      r_rst_n     <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_stage <= 3'd0;
    end else begin
      r_rst_n     <= w_nxt_rst_n;
      r_done      <= w_nxt_done;
      r_err       <= w_nxt_err;
      r_err_stage <= w_nxt_err_stage;
    end
  end

  assign STAGE_RESET_N = r_rst_n;
  assign SEQ_DONE      = r_done;
  assign SEQ_ERROR     = r_err;
  assign ERR_STAGE     = r_err_stage;

endmodule

// File: tb/tb_reset_sequencer_pf.sv
// Bench for reset_sequencer_pf. Expected outputs come from an event-timeline
// model, which works out each stage's release edge and the done/error edges
// with plain arithmetic. Edge 1 is the first rising edge after INTERNAL_RST
// deasserts.
module tb_reset_sequencer_pf;
  localparam int NS  = 4;
  localparam int SD  = 16;
  localparam int TO  = 256;
  localparam int INF = 1000000000;

  logic          CLK          = 1'b0;
  logic          INTERNAL_RST = 1'b0;
  logic          SOFT_RST_REQ = 1'b0;
  logic [NS-1:0] STAGE_ACK    = '0;
  logic [NS-1:0] STAGE_RESET_N;
  logic          SEQ_DONE;
  logic          SEQ_ERROR;
  logic [2:0]    ERR_STAGE;
  logic [8:0]    obs;
  logic [8:0]    exp_v;

  int n_cmp = 0;
  int n_bad = 0;
  int g_e = 0;
  int g_base = 0;
  int g_pre [NS];
  int g_d   [NS];
  int m_rel [NS];
  int m_t   [NS];
  int m_done;
  int m_err;
  int m_es;
  int drop_edge = INF;
  int drop_k    = 0;
  int soft_edge = INF;

  reset_sequencer_pf #(.NUM_STAGES(NS), .STAGE_DELAY(SD), .TIMEOUT(TO)) dut (
    .CLK          (CLK),
    .INTERNAL_RST (INTERNAL_RST),
    .SOFT_RST_REQ (SOFT_RST_REQ),
    .STAGE_ACK    (STAGE_ACK),
    .STAGE_RESET_N(STAGE_RESET_N),
    .SEQ_DONE     (SEQ_DONE),
    .SEQ_ERROR    (SEQ_ERROR),
    .ERR_STAGE    (ERR_STAGE)
  );

  always #5 CLK = ~CLK;

  assign obs = {STAGE_RESET_N, SEQ_DONE, SEQ_ERROR, ERR_STAGE};

  // Timeline model. The first release lands 17 edges after the base. An ack
  // driven after edge t is acted on at edge t+3, never before the edge after
  // the release. The next release follows 17 edges later. A stage whose ack
  // edge is more than TO edges after its release times out at release+TO.
  function automatic void build_model();
    int  cur;
    int  x;
    bit  stop;
    cur    = g_base + SD + 1;
    m_done = INF;
    m_err  = INF;
    m_es   = 0;
    stop   = 1'b0;
    for (int k = 0; k < NS; k++) begin
      m_rel[k] = INF;
      m_t[k]   = g_pre[k];
    end
    for (int k = 0; k < NS; k++) begin
      if (!stop) begin
        m_rel[k] = cur;
        if (g_d[k] < INF && cur + g_d[k] < m_t[k]) m_t[k] = cur + g_d[k];
        x = (m_t[k] + 3 > cur + 1) ? m_t[k] + 3 : cur + 1;
        if (x - cur > TO) begin
          m_err = cur + TO;
          m_es  = k;
          stop  = 1'b1;
        end else if (k == NS - 1) begin
          m_done = x;
        end else begin
          cur = x + SD + 1;
        end
      end
    end
  endfunction

  // Expected {resets, done, error, err_stage} after edge e.
  function automatic logic [8:0] exp_at(input int e);
    logic [NS-1:0] r;
    logic          d;
    logic          er;
    int            err_e;
    int            es;
    err_e = m_err;
    es    = m_es;
    if (drop_edge < INF && drop_edge + 3 < err_e) begin
      err_e = drop_edge + 3;
      es    = drop_k;
    end
    for (int k = 0; k < NS; k++) r[k] = (e >= m_rel[k]) && (e < err_e);
    d  = (e >= m_done) && (e < err_e);
    er = (e >= err_e);
    return {r, d, er, er ? 3'(es) : 3'd0};
  endfunction

  task automatic drive();
    for (int k = 0; k < NS; k++)
      STAGE_ACK[k] = (g_e >= m_t[k]) && !(g_e >= drop_edge && k == drop_k);
    SOFT_RST_REQ = (g_e == soft_edge - 1);
  endtask

  task automatic step();
    @(posedge CLK);
    g_e++;
    #1;
    drive();
  endtask

  task automatic set_plan(input int d0, input int d1, input int d2, input int d3);
    g_base = 0;
    for (int k = 0; k < NS; k++) g_pre[k] = INF;
    g_d[0] = d0; g_d[1] = d1; g_d[2] = d2; g_d[3] = d3;
  endtask

  task automatic apply_reset();
    INTERNAL_RST = 1'b0;
    SOFT_RST_REQ = 1'b0;
    drop_edge    = INF;
    soft_edge    = INF;
    repeat (3) @(negedge CLK);
    g_e = 0;
    build_model();
    drive();
    INTERNAL_RST = 1'b1;
  endtask

  task automatic test_reset();
    INTERNAL_RST = 1'b0;
    #3;
    n_cmp++;
    if (obs !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_async: got rst/done/err/es=%b want 000000000", obs);
    end
    repeat (4) @(posedge CLK);
    #1;
    n_cmp++;
    if (obs !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_hold: got rst/done/err/es=%b want 000000000", obs);
    end
  endtask

  task automatic test_nominal();
    int rise [NS];
    set_plan(3, 3, 3, 3);
    apply_reset();
    for (int k = 0; k < NS; k++) rise[k] = INF;
    while (g_e < m_done + 12) begin
      step();
      for (int k = 0; k < NS; k++) if (STAGE_RESET_N[k] && rise[k] == INF) rise[k] = g_e;
      exp_v = exp_at(g_e);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL nominal e=%0d: got rst/done/err/es=%b want %b", g_e, obs, exp_v);
      end
    end
    n_cmp++;
    if (rise[0] !== 17) begin
      n_bad++;
      $display("FAIL nominal_first_release: got edge %0d want 17", rise[0]);
    end
    for (int k = 1; k < NS; k++) begin
      n_cmp++;
      if (rise[k] - rise[k-1] < SD) begin
        n_bad++;
        $display("FAIL nominal_spacing stage %0d: got gap %0d want >= %0d", k, rise[k] - rise[k-1], SD);
      end
    end
  endtask

  task automatic test_drop_in_done();
    drop_k    = 1;
    drop_edge = g_e + 1;
    repeat (10) begin
      step();
      exp_v = exp_at(g_e);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL drop_in_done e=%0d: got rst/done/err/es=%b want %b", g_e, obs, exp_v);
      end
    end
  endtask

  task automatic test_timeout();
    set_plan(3, 3, INF, 3);
    apply_reset();
    while (g_e < m_err + 20) begin
      step();
      exp_v = exp_at(g_e);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL timeout e=%0d: got rst/done/err/es=%b want %b", g_e, obs, exp_v);
      end
    end
    n_cmp++;
    if (obs !== {4'b0000, 1'b0, 1'b1, 3'd2}) begin
      n_bad++;
      $display("FAIL timeout_final: got rst/done/err/es=%b want 000001010", obs);
    end
  endtask

  task automatic test_recover();
    bit switched;
    int a_edge;
    switched = 1'b0;
    a_edge   = g_e + 1;
    for (int k = 0; k < NS; k++) if (m_t[k] > a_edge) m_t[k] = a_edge;
    soft_edge = g_e + 8;
    while (!switched || g_e < m_done + 10) begin
      step();
      if (g_e == soft_edge) begin
        g_base = g_e + 1;
        for (int k = 0; k < NS; k++) begin
          g_pre[k] = m_t[k];
          g_d[k]   = INF;
        end
        build_model();
        switched = 1'b1;
      end
      exp_v = exp_at(g_e);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL recover e=%0d: got rst/done/err/es=%b want %b", g_e, obs, exp_v);
      end
    end
  endtask

  task automatic test_soft_vs_ack();
    bit switched;
    switched = 1'b0;
    set_plan(2, 4, 3, 3);
    apply_reset();
    soft_edge = m_t[1] + 3;
    while (!switched || g_e < m_done + 10) begin
      step();
      if (g_e == soft_edge) begin
        g_base = g_e + 1;
        for (int k = 0; k < NS; k++) g_pre[k] = (m_t[k] < soft_edge) ? m_t[k] : INF;
        g_d[0] = INF; g_d[1] = INF; g_d[2] = 5; g_d[3] = 6;
        build_model();
        switched = 1'b1;
        n_cmp++;
        if (STAGE_RESET_N !== '0) begin
          n_bad++;
          $display("FAIL soft_vs_ack_assert: got resets %b want 0000", STAGE_RESET_N);
        end
      end
      exp_v = exp_at(g_e);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL soft_vs_ack e=%0d: got rst/done/err/es=%b want %b", g_e, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int mid;
    int rise0;
    set_plan(3, 3, 3, 3);
    apply_reset();
    mid = m_rel[3] - 9;
    while (g_e < mid) begin
      step();
      exp_v = exp_at(g_e);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL mid_hold_pre e=%0d: got rst/done/err/es=%b want %b", g_e, obs, exp_v);
      end
    end
    #2;
    INTERNAL_RST = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 9'd0) begin
      n_bad++;
      $display("FAIL mid_hold_async: got rst/done/err/es=%b want 000000000", obs);
    end
    g_base = 0;
    for (int k = 0; k < NS; k++) begin
      g_pre[k] = -10;
      g_d[k]   = INF;
    end
    apply_reset();
    rise0 = INF;
    while (g_e < m_done + 8) begin
      step();
      if (STAGE_RESET_N[0] && rise0 == INF) rise0 = g_e;
      exp_v = exp_at(g_e);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL mid_hold_restart e=%0d: got rst/done/err/es=%b want %b", g_e, obs, exp_v);
      end
    end
    n_cmp++;
    if (rise0 !== 17) begin
      n_bad++;
      $display("FAIL mid_hold_first_release: got edge %0d want 17", rise0);
    end
  endtask

  task automatic test_random();
    int r;
    int end_e;
    for (int it = 0; it < 6; it++) begin
      g_base = 0;
      for (int k = 0; k < NS; k++) begin
        g_pre[k] = INF;
        r = $urandom_range(9, 0);
        if (r < 7)      g_d[k] = $urandom_range(30, 0);
        else if (r < 9) g_d[k] = $urandom_range(256, 250);
        else            g_d[k] = INF;
      end
      apply_reset();
      end_e = ((m_done < m_err) ? m_done : m_err) + 10;
      while (g_e < end_e) begin
        step();
        exp_v = exp_at(g_e);
        n_cmp++;
        if (obs !== exp_v) begin
          n_bad++;
          $display("FAIL random it=%0d e=%0d: got rst/done/err/es=%b want %b", it, g_e, obs, exp_v);
        end
      end
      if (m_done < INF && (it % 2) == 1) begin
        drop_k    = $urandom_range(NS - 1, 0);
        drop_edge = g_e + 1;
        repeat (8) begin
          step();
          exp_v = exp_at(g_e);
          n_cmp++;
          if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL random_drop it=%0d e=%0d: got rst/done/err/es=%b want %b", it, g_e, obs, exp_v);
          end
        end
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_drop_in_done();
    test_timeout();
    test_recover();
    test_soft_vs_ack();
    test_reset_mid_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reset_sequencer_pf.md
RESET_SEQUENCER_PF -- requirements
Module: reset_sequencer_pf

Interface
REQ-001 The block SHALL use clock CLK, and reset INTERNAL_RST, asynchronous, active-low.
REQ-002 Parameters SHALL be as follows, one per line (name, default, meaning):
- NUM_STAGES, 4, number of sequenced reset domains, legal range 1..8.
- STAGE_DELAY, 16, hold cycles before each stage release, legal range 1..255.
- TIMEOUT, 256, maximum ack-wait cycles per stage, legal range 2..65535.
REQ-003 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- CLK, in, 1, sequencer clock.
- INTERNAL_RST, in, 1, combined async active-low reset from the reset synchroniser.
- SOFT_RST_REQ, in, 1, synchronous single-cycle request to re-run the full sequence.
- STAGE_ACK, in, NUM_STAGES, per-domain "out of reset/ready" acks; may be asynchronous.
- STAGE_RESET_N, out, NUM_STAGES, registered per-domain active-low resets.
- SEQ_DONE, out, 1, all stages released and acked.
- SEQ_ERROR, out, 1, a stage timed out or dropped its ack.
- ERR_STAGE, out, 3, index of the failing stage.

Function
REQ-004 Each STAGE_ACK bit SHALL pass through a 2-flop synchroniser (ack_s) reset to 0; all FSM decisions SHALL use ack_s only.
REQ-005 The FSM SHALL have states HOLD, RELEASE, WAIT_ACK, DONE, ERROR and ASSERT, with a stage index idx (3 bits) and a 16-bit counter cnt.
REQ-006 HOLD behaviour:
- cnt increments every cycle.
- When cnt==STAGE_DELAY-1, the FSM goes to RELEASE and cnt clears.
- HOLD therefore lasts exactly STAGE_DELAY cycles.
REQ-007 RELEASE SHALL last one cycle: STAGE_RESET_N[idx] is set to 1 at the exit edge, then the FSM goes to WAIT_ACK with cnt=0.
REQ-008 WAIT_ACK behaviour:
- cnt increments each cycle.
- If ack_s[idx]==1 and idx==NUM_STAGES-1, the FSM goes to DONE.
- If ack_s[idx]==1 and idx<NUM_STAGES-1, idx increments, cnt clears, and the FSM goes to HOLD.
- If ack_s[idx]==0 and cnt==TIMEOUT-1, the FSM goes to ERROR.
- If the ack and the timeout occur in the same cycle, the ack SHALL win.
REQ-009 Stages SHALL be released strictly in ascending index order; released stages SHALL stay released through later stages.
REQ-010 In DONE, SEQ_DONE SHALL be 1; if any ack_s bit falls to 0, the FSM goes to ERROR with ERR_STAGE set to the lowest dropped index.
REQ-011 On entry to ERROR:
- SEQ_ERROR=1, SEQ_DONE=0.
- ERR_STAGE=idx on timeout, or the dropped index per REQ-010.
- All STAGE_RESET_N bits are driven to 0.
- ERROR SHALL be held until INTERNAL_RST or SOFT_RST_REQ.
REQ-012 SOFT_RST_REQ=1 in any state SHALL move the FSM to ASSERT on the next edge and SHALL take priority over acks and timeouts in the same cycle.
REQ-013 ASSERT SHALL last one cycle and then go to HOLD, and SHALL:
- drive all STAGE_RESET_N=0;
- clear SEQ_DONE, SEQ_ERROR, ERR_STAGE, idx and cnt.
REQ-014 SOFT_RST_REQ arriving while in ASSERT SHALL be ignored.
REQ-015 All outputs SHALL be registered; no output SHALL be combinationally dependent on any input.
REQ-016 ERR_STAGE SHALL be zero-extended when NUM_STAGES<8; idx SHALL never exceed NUM_STAGES-1.

Reset
REQ-017 While INTERNAL_RST=0, the block SHALL hold:
- STAGE_RESET_N all 0, SEQ_DONE=0, SEQ_ERROR=0, ERR_STAGE=0;
- state HOLD, idx=0, cnt=0, ack_s=0.
REQ-018 Reset assertion SHALL take effect immediately, without CLK, from any state, including mid-sequence and ERROR.
REQ-019 After INTERNAL_RST deasserts, the first rising CLK edge SHALL be HOLD cycle 1.
REQ-020 With default parameters, STAGE_RESET_N[0] SHALL rise at edge 17.

Verification
REQ-021 The bench SHALL cover the following directed scenarios (default parameters):
- Nominal sequence: reset release, with each ack raised 3 cycles after its STAGE_RESET_N rises -> bits 0..3 rise in order, each ≥16 cycles apart, then SEQ_DONE=1 and SEQ_ERROR=0.
- Stage 2 timeout: STAGE_ACK[2] tied 0 -> 256 cycles after STAGE_RESET_N[2] rises, SEQ_ERROR=1, ERR_STAGE=2, STAGE_RESET_N=4'b0000, SEQ_DONE=0.
- Ack drop in DONE: drop STAGE_ACK[1] -> SEQ_ERROR=1, ERR_STAGE=1 within 3 cycles, all resets 0.
- SOFT_RST_REQ in the same cycle as ack_s[1] rising in WAIT_ACK -> ASSERT wins, all resets 0 next cycle, and the sequence restarts from stage 0.
- INTERNAL_RST pulsed low mid-HOLD of stage 3 -> all outputs return to reset values asynchronously, and the sequence restarts with STAGE_RESET_N[0] at edge 17.
- Recovery from ERROR via SOFT_RST_REQ with all acks high -> SEQ_ERROR clears, and SEQ_DONE=1 after the full sequence completes.
